// File: rtl/rojobot_nav_ctl.sv
// rojobot_nav_ctl
//   Line-following navigation controller for the Rojobot external-world
//   interface. Every toggle of the PicoBlaze update flag is one update event.
//   On each event the controller evaluates the sensor register, runs the
//   follow/search/obstacle state machine and drives the motor control
//   register. A watchdog halts the bot if update events stop arriving.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   enable      run request; low forces IDLE
//   upd_sysregs update flag, each edge is one update event
//   Sensors     [0] right, [1] center, [2] left line (0 = line present);
//               [3] right, [4] left proximity (1 = object); [7:5] unused
//   MotCtl      registered {lm_spd[2:0], lm_dir, rm_spd[2:0], rm_dir}
//   nav_state   IDLE=0 FOLLOW=1 SEARCH=2 OBSTACLE=3 HALT=4
//   wd_err      sticky watchdog expiry flag
//   lost        sticky search-exhausted flag
//   upd_cnt     update events seen since reset (wraps)
module rojobot_nav_ctl #(
    parameter logic [2:0]  FWD_SPD      = 3'd4,
    parameter logic [2:0]  TURN_SPD     = 3'd2,
    parameter int          LOST_LIMIT   = 4,
    parameter int          SEARCH_LIMIT = 32,
    parameter logic [23:0] WD_CYCLES    = 24'd5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       upd_sysregs,
    input  logic [7:0] Sensors,
    output logic [7:0] MotCtl,
    output logic [2:0] nav_state,
    output logic       wd_err,
    output logic       lost,
    output logic [7:0] upd_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FOLLOW   = 3'd1,
        S_SEARCH   = 3'd2,
        S_OBSTACLE = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    localparam logic [7:0]  DRV_FWD    = {FWD_SPD, 1'b1, FWD_SPD, 1'b1};
    localparam logic [7:0]  DRV_VEER_L = {TURN_SPD, 1'b1, FWD_SPD, 1'b1};
    localparam logic [7:0]  DRV_VEER_R = {FWD_SPD, 1'b1, TURN_SPD, 1'b1};
    localparam logic [7:0]  DRV_SPIN   = {TURN_SPD, 1'b1, TURN_SPD, 1'b0};
    localparam logic [7:0]  DRV_STOP   = 8'h00;
    localparam logic [7:0]  LOST_LIM   = 8'(LOST_LIMIT);
    localparam logic [7:0]  SEARCH_LIM = 8'(SEARCH_LIMIT);
    localparam logic [23:0] WD_LAST    = WD_CYCLES - 24'd1;

    // Returns {line_found, drive_code}; center beats left beats right.
    function automatic logic [8:0] line_decode(input logic [2:0] lcr);
        logic [8:0] res;
        res = {1'b0, DRV_STOP};
        if (!lcr[1])      res = {1'b1, DRV_FWD};
        else if (!lcr[2]) res = {1'b1, DRV_VEER_L};
        else if (!lcr[0]) res = {1'b1, DRV_VEER_R};
        return res;
    endfunction

    state_t      state_q, state_n;
    logic [7:0]  mot_q, mot_n;
    logic [7:0]  lost_cnt_q, lost_cnt_n;
    logic [7:0]  search_cnt_q, search_cnt_n;
    logic [23:0] wd_cnt_q, wd_cnt_n;
    logic        wd_err_q, wd_err_n;
    logic        lost_q, lost_n;
    logic [7:0]  upd_cnt_q, upd_cnt_n;
    logic        upd_q;

    logic        upd_evt;
    logic        obstacle;
    logic        line_found;
    logic [7:0]  line_code;
    logic [7:0]  lost_inc;
    logic [7:0]  search_inc;
    logic        sensors_unused;

    assign upd_evt                 = upd_sysregs ^ upd_q;
    assign obstacle                = Sensors[4] | Sensors[3];
    assign {line_found, line_code} = line_decode(Sensors[2:0]);
    assign lost_inc                = lost_cnt_q + 8'd1;
    assign search_inc              = search_cnt_q + 8'd1;
    // Upper sensor bits carry nothing this controller uses.
    assign sensors_unused          = ^Sensors[7:5];

    always_comb begin
        state_n      = state_q;
        mot_n        = mot_q;
        lost_cnt_n   = lost_cnt_q;
        search_cnt_n = search_cnt_q;
        wd_cnt_n     = wd_cnt_q;
        wd_err_n     = wd_err_q;
        lost_n       = lost_q;
        upd_cnt_n    = upd_cnt_q + {7'd0, upd_evt};

        case (state_q)
            S_IDLE: begin
                mot_n = DRV_STOP;
                if (enable) begin
                    state_n      = S_FOLLOW;
                    lost_cnt_n   = '0;
                    search_cnt_n = '0;
                    wd_cnt_n     = '0;
                    wd_err_n     = 1'b0;
                    lost_n       = 1'b0;
                end
            end
            S_FOLLOW, S_SEARCH, S_OBSTACLE: begin
                if (upd_evt) begin
                    // An update on the expiry cycle wins over the watchdog.
                    wd_cnt_n = '0;
                    if (obstacle) begin
                        state_n = S_OBSTACLE;
                        mot_n   = DRV_STOP;
                    end else if (line_found) begin
                        state_n    = S_FOLLOW;
                        mot_n      = line_code;
                        lost_cnt_n = '0;
                    end else if (state_q == S_SEARCH) begin
                        search_cnt_n = search_inc;
                        if (search_inc == SEARCH_LIM) begin
                            state_n = S_HALT;
                            lost_n  = 1'b1;
                            mot_n   = DRV_STOP;
                        end
                    end else begin
                        // FOLLOW, or an obstacle just cleared with no line
                        // in view: keep the current drive and count the miss.
                        state_n    = S_FOLLOW;
                        lost_cnt_n = lost_inc;
                        if (lost_inc == LOST_LIM) begin
                            state_n      = S_SEARCH;
                            mot_n        = DRV_SPIN;
                            search_cnt_n = '0;
                            lost_cnt_n   = '0;
                        end
                    end
                end else if (wd_cnt_q == WD_LAST) begin
                    state_n  = S_HALT;
                    wd_err_n = 1'b1;
                    mot_n    = DRV_STOP;
                    wd_cnt_n = '0;
                end else begin
                    wd_cnt_n = wd_cnt_q + 24'd1;
                end
            end
            S_HALT: begin
                mot_n = DRV_STOP;
            end
            default: begin
                state_n = S_IDLE;
                mot_n   = DRV_STOP;
            end
        endcase

        // Dropping enable beats any update; the event is still counted.
        if (!enable) begin
            state_n = S_IDLE;
            mot_n   = DRV_STOP;
        end
    end

    always_ff @(posedge clk) begin
        // Follows the flag during reset too, so release sees no false event.
        upd_q <= upd_sysregs;
        if (reset) begin
            state_q      <= S_IDLE;
            mot_q        <= DRV_STOP;
            lost_cnt_q   <= '0;
            search_cnt_q <= '0;
            wd_cnt_q     <= '0;
            wd_err_q     <= 1'b0;
            lost_q       <= 1'b0;
            upd_cnt_q    <= '0;
        end else begin
            state_q      <= state_n;
            mot_q        <= mot_n;
            lost_cnt_q   <= lost_cnt_n;
            search_cnt_q <= search_cnt_n;
            wd_cnt_q     <= wd_cnt_n;
            wd_err_q     <= wd_err_n;
            lost_q       <= lost_n;
            upd_cnt_q    <= upd_cnt_n;
        end
    end

    assign MotCtl    = mot_q;
    assign nav_state = state_q;
    assign wd_err    = wd_err_q;
    assign lost      = lost_q;
    assign upd_cnt   = upd_cnt_q;

endmodule

// File: tb/tb_rojobot_nav_ctl.sv
// Testbench for rojobot_nav_ctl: directed scenarios followed by randomized
// update traffic, all checked against a behavioural reference model.
module tb_rojobot_nav_ctl;

    localparam int WD = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       upd_sysregs;
    logic [7:0] Sensors;
    logic [7:0] MotCtl;
    logic [2:0] nav_state;
    logic       wd_err;
    logic       lost;
    logic [7:0] upd_cnt;

    always #5 clk = ~clk;

    rojobot_nav_ctl #(
        .WD_CYCLES(24'd100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .upd_sysregs(upd_sysregs),
        .Sensors    (Sensors),
        .MotCtl     (MotCtl),
        .nav_state  (nav_state),
        .wd_err     (wd_err),
        .lost       (lost),
        .upd_cnt    (upd_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: state numbers as the nav_state encoding, counters as ints.
    int         m_state;
    logic [7:0] m_mot;
    bit         m_wd_err, m_lost;
    int         m_upd_cnt, m_lost_cnt, m_search_cnt, m_quiet;
    logic       m_upd_prev;

    function automatic int line_code(input logic [7:0] s);
        if (s[1] == 1'b0) return 'h99;
        if (s[2] == 1'b0) return 'h59;
        if (s[0] == 1'b0) return 'h95;
        return -1;
    endfunction

    task automatic model_step();
        bit evt;
        int d;
        if (reset) begin
            m_state = 0; m_mot = 8'h00; m_wd_err = 0; m_lost = 0;
            m_upd_cnt = 0; m_lost_cnt = 0; m_search_cnt = 0; m_quiet = 0;
            m_upd_prev = upd_sysregs;
            return;
        end
        evt = (upd_sysregs != m_upd_prev);
        m_upd_prev = upd_sysregs;
        if (evt) m_upd_cnt = (m_upd_cnt + 1) % 256;
        if (!enable) begin
            m_state = 0; m_mot = 8'h00;
            return;
        end
        if (m_state == 0) begin
            m_mot = 8'h00;
            m_state = 1; m_lost_cnt = 0; m_search_cnt = 0; m_quiet = 0;
            m_wd_err = 0; m_lost = 0;
            return;
        end
        if (m_state == 4) begin
            m_mot = 8'h00;
            return;
        end
        if (!evt) begin
            m_quiet++;
            if (m_quiet == WD) begin
                m_state = 4; m_wd_err = 1; m_mot = 8'h00; m_quiet = 0;
            end
            return;
        end
        m_quiet = 0;
        d = line_code(Sensors);
        if (Sensors[4] || Sensors[3]) begin
            m_state = 3; m_mot = 8'h00;
        end else if (d >= 0) begin
            m_state = 1; m_mot = d[7:0]; m_lost_cnt = 0;
        end else if (m_state == 2) begin
            m_search_cnt++;
            if (m_search_cnt == 32) begin
                m_state = 4; m_lost = 1; m_mot = 8'h00;
            end
        end else begin
            m_state = 1;
            m_lost_cnt++;
            if (m_lost_cnt == 4) begin
                m_state = 2; m_mot = 8'h54; m_search_cnt = 0; m_lost_cnt = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_val("MotCtl", MotCtl, m_mot);
        check_val("nav_state", nav_state, m_state);
        check_val("wd_err", wd_err, m_wd_err);
        check_val("lost", lost, m_lost);
        check_val("upd_cnt", upd_cnt, m_upd_cnt);
    endtask

    task automatic toggle(input logic [7:0] s);
        Sensors = s;
        upd_sysregs = ~upd_sysregs;
        tick();
    endtask

    initial begin
        int cnt_before;
        int tprob;
        logic [7:0] s;

        reset = 1'b1; enable = 1'b0; upd_sysregs = 1'b1; Sensors = 8'h07;
        repeat (3) tick();
        check_val("rst_mot", MotCtl, 32'h00);
        check_val("rst_state", nav_state, 32'd0);
        reset = 1'b0;
        tick();
        check_val("no_spurious_evt", upd_cnt, 32'd0);

        // Line following
        enable = 1'b1;
        tick();
        toggle(8'h05); check_val("drv_fwd", MotCtl, 32'h99);
        toggle(8'h03); check_val("drv_veer_l", MotCtl, 32'h59);
        toggle(8'h06); check_val("drv_veer_r", MotCtl, 32'h95);
        check_val("upd_cnt3", upd_cnt, 32'd3);

        // Obstacle
        toggle(8'h1D); check_val("obst_state", nav_state, 32'd3);
        check_val("obst_mot", MotCtl, 32'h00);
        toggle(8'h05); check_val("obst_exit", nav_state, 32'd1);
        check_val("obst_exit_mot", MotCtl, 32'h99);

        // Lost line then search exhaustion
        repeat (3) begin toggle(8'h07); tick(); end
        check_val("lost_hold", MotCtl, 32'h99);
        toggle(8'h07);
        check_val("search_state", nav_state, 32'd2);
        check_val("spin", MotCtl, 32'h54);
        repeat (32) toggle(8'h07);
        check_val("halt_state", nav_state, 32'd4);
        check_val("lost_flag", lost, 1'b1);
        check_val("halt_mot", MotCtl, 32'h00);
        enable = 1'b0; tick();
        check_val("to_idle", nav_state, 32'd0);

        // Watchdog expiry at cycle WD
        enable = 1'b1; tick();
        repeat (WD - 1) tick();
        check_val("wd_pre", nav_state, 32'd1);
        tick();
        check_val("wd_halt", nav_state, 32'd4);
        check_val("wd_err", wd_err, 1'b1);
        // Update on the expiry cycle wins
        enable = 1'b0; tick();
        enable = 1'b1; tick();
        repeat (WD - 1) tick();
        toggle(8'h05);
        check_val("wd_saved", nav_state, 32'd1);
        check_val("wd_saved_err", wd_err, 1'b0);

        // enable drop beats a simultaneous update
        cnt_before = m_upd_cnt;
        enable = 1'b0;
        toggle(8'h06);
        check_val("dis_state", nav_state, 32'd0);
        check_val("dis_mot", MotCtl, 32'h00);
        check_val("dis_cnt", upd_cnt, (cnt_before + 1) % 256);

        // Reset while in SEARCH
        enable = 1'b1; tick();
        toggle(8'h05);
        repeat (4) toggle(8'h07);
        check_val("pre_rst_search", nav_state, 32'd2);
        reset = 1'b1; tick();
        check_val("rst2_state", nav_state, 32'd0);
        check_val("rst2_mot", MotCtl, 32'h00);
        check_val("rst2_cnt", upd_cnt, 32'd0);
        reset = 1'b0; tick();

        // Randomized traffic with bursts, quiet spells and rare reset/disable
        tprob = 40;
        for (int i = 0; i < 4000; i++) begin
            if (i % 256 == 0) begin
                case ($urandom_range(0, 3))
                    0: tprob = 0;
                    1: tprob = 5;
                    2: tprob = 40;
                    default: tprob = 90;
                endcase
            end
            reset = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 79) == 0) enable = ~enable;
            s = 8'($urandom);
            if ($urandom_range(0, 3) != 0) s[4:3] = 2'b00;
            if ($urandom_range(0, 1) == 1) s[2:0] = 3'b111;
            Sensors = s;
            if ($urandom_range(0, 99) < tprob) upd_sysregs = ~upd_sysregs;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rojobot_nav_ctl.md
Name: rojobot_nav_ctl

Overview:
- Hardware line-following controller for the Rojobot external-world interface.
- Detects each system-register update by watching the PicoBlaze update flag for toggles, and evaluates the synchronized Sensors register on each update.
- Drives the 8-bit motor control register back to the Rojobot.
- Runs a follow/search/obstacle state machine and a watchdog that halts the bot if updates stop arriving.

Parameters:
- FWD_SPD, 3'd4: motor speed for straight and outer-wheel drive.
- TURN_SPD, 3'd2: inner-wheel speed when veering; both-wheel speed in search.
- LOST_LIMIT, 4: consecutive no-line updates in FOLLOW before entering SEARCH (range 1..255).
- SEARCH_LIMIT, 32: updates in SEARCH without finding a line before HALT (range 1..255).
- WD_CYCLES, 24'd5_000_000: clock cycles without an update before HALT (range 1..2^24-1).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: run request; low forces IDLE.
- upd_sysregs, in, 1: update flag; each toggle (either edge) is one update event.
- Sensors, in, 8: synchronized sensor register.
  - [0] right line, [1] center line, [2] left line; 0 = black line present.
  - [3] right proximity, [4] left proximity; 1 = object present.
  - [7:5] ignored.
- MotCtl, out, 8: motor control {lm_spd[2:0], lm_dir, rm_spd[2:0], rm_dir}; dir 1 = forward. Registered.
- nav_state, out, 3: IDLE=0, FOLLOW=1, SEARCH=2, OBSTACLE=3, HALT=4.
- wd_err, out, 1: sticky; set on watchdog expiry.
- lost, out, 1: sticky; set when SEARCH_LIMIT is exhausted.
- upd_cnt, out, 8: update events seen since reset; wraps 255->0.

Behaviour:
- Reset values:
  - MotCtl = 0, nav_state = IDLE, wd_err = 0, lost = 0, upd_cnt = 0.
  - lost_cnt = 0, search_cnt = 0, wd counter = 0.
  - upd_q loads upd_sysregs, so the first cycle after reset sees no spurious event.
- Update detection:
  - upd_q <= upd_sysregs every cycle; upd_evt = upd_sysregs ^ upd_q.
  - Sensors are sampled on the edge where upd_evt = 1; MotCtl changes on that same edge. Latency is 1 clk from the upd_sysregs transition.
  - Toggles on consecutive cycles each count as an event.
  - upd_cnt increments on every upd_evt in every state except during reset.
- Drive codes (defaults in brackets):
  - FWD = {FWD_SPD,1,FWD_SPD,1} [0x99]
  - VEER_L = {TURN_SPD,1,FWD_SPD,1} [0x59]
  - VEER_R = {FWD_SPD,1,TURN_SPD,1} [0x95]
  - SPIN = {TURN_SPD,1,TURN_SPD,0} [0x54]
  - STOP = 0x00
- Line decode, with L, C, R = Sensors[2:0], first match wins:
  - C = 0 -> FWD.
  - L = 0 -> VEER_L.
  - R = 0 -> VEER_R.
  - L, C, R all 1 -> no line.
- IDLE:
  - MotCtl = STOP.
  - enable = 1 -> FOLLOW at the next edge; lost_cnt, search_cnt, wd counter, wd_err and lost cleared.
  - MotCtl is not driven until the first update event.
- FOLLOW, on each upd_evt, first match wins:
  - Sensors[4] | Sensors[3] -> OBSTACLE, MotCtl = STOP.
  - Line found -> apply the decoded drive code; lost_cnt = 0.
  - No line -> hold MotCtl; lost_cnt++. If the incremented value equals LOST_LIMIT -> SEARCH, MotCtl = SPIN, search_cnt = 0.
- SEARCH, on upd_evt:
  - Obstacle -> OBSTACLE with STOP.
  - Any line bit 0 -> FOLLOW with the decoded drive code; lost_cnt = 0.
  - Otherwise search_cnt++. Reaching SEARCH_LIMIT -> HALT, lost = 1, MotCtl = STOP.
- OBSTACLE:
  - MotCtl = STOP.
  - On an upd_evt with Sensors[4:3] = 00 -> FOLLOW with the decoded drive code from that update's line bits; no line -> hold STOP and lost_cnt++.
- HALT:
  - MotCtl = STOP; wd_err and lost hold.
  - Exits only when enable = 0 -> IDLE.
- Watchdog:
  - Counts clocks in FOLLOW, SEARCH and OBSTACLE; cleared on upd_evt and on any state entry from IDLE.
  - Count reaching WD_CYCLES -> HALT, wd_err = 1, MotCtl = STOP.
  - If upd_evt coincides with expiry, the update wins and the counter clears.
- enable = 0 in any state -> IDLE and MotCtl = STOP at the next edge. This overrides a simultaneous upd_evt, but upd_cnt still increments.
- reset asserted mid-operation -> all reset values at the next edge, regardless of state or pending event.
- Counters saturate below their limits: the limit comparison triggers the transition, so they never pass the limit.

Test Plan:
- Reset with upd_sysregs = 1 -> MotCtl = 0x00, nav_state = 0, upd_cnt = 0. No event on the first cycle after release.
- Line following: enable = 1, then toggles with Sensors = 0x05, 0x03, 0x06 -> MotCtl = 0x99, 0x59, 0x95, each 1 clk after its toggle; upd_cnt = 3.
- Obstacle: in FOLLOW, toggle with Sensors = 0x1D -> nav_state = 3, MotCtl = 0x00. Toggle with Sensors = 0x05 -> nav_state = 1, MotCtl = 0x99.
- Lost line:
  - In FOLLOW after 0x99, apply 4 toggles with Sensors = 0x07 -> MotCtl holds 0x99 for 3 updates, then nav_state = 2 and MotCtl = 0x54.
  - Then 32 further 0x07 toggles -> nav_state = 4, lost = 1, MotCtl = 0x00.
  - enable = 0 -> nav_state = 0.
- Watchdog: WD_CYCLES = 100, FOLLOW with no toggles -> at cycle 100 nav_state = 4, wd_err = 1. Repeat with a toggle exactly at cycle 100 -> stays in FOLLOW.
- Priority: drop enable on the same cycle as a toggle -> IDLE, MotCtl = 0x00, upd_cnt increments. Assert reset in SEARCH -> all outputs return to their reset values next edge.
